mem_read_master: RTL and testbench
==================================

Name: mem_read_master

Overview:
Initiator side of the processor/memory read interface. Accepts one load request at a time from the core and issues a single-cycle read strobe with a word-aligned address. Captures the returned word after the memory's read latency, then extracts and extends the requested byte, halfword or word. Sits between the core's execute/fetch logic and the Memory block. Misaligned requests are rejected without touching memory.

Parameters:
LATENCY, 1, cycles from the strobe cycle until mem_rdata is valid; Memory returns data registered, so 1; legal range 1..15
ADDR_W, 32, width of request and memory address

Ports:
clk  in  1  system clock; all state on posedge
resetn  in  1  reset; one clock; asynchronous, active-low
req_valid  in  1  core presents a read request
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  byte address
req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
req_unsigned  in  1  1=zero-extend, 0=sign-extend (byte/half only)
rsp_valid  out  1  one-cycle pulse, response valid
rsp_data  out  32  extracted/extended data
rsp_err  out  1  qualifies rsp_valid: misaligned request, rsp_data=0
mem_addr  out  ADDR_W  word-aligned address, bits[1:0]=0
mem_rstrb  out  1  read strobe, exactly one cycle per read
mem_rdata  in  32  word from memory

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; mem_rstrb=0, mem_addr=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - Latched request fields and the wait counter are cleared.
  - Reset mid-transaction drops the transaction; no rsp_valid is ever produced for it.
- States:
  - IDLE: waiting for a request.
  - ISSUE: mem_rstrb=1 for this cycle only.
  - WAIT: count LATENCY cycles.
  - RESP: rsp_valid=1.
  - ERR: rsp_valid=1, rsp_err=1.
- req_ready = (state==IDLE) or (state==RESP) or (state==ERR). A request is accepted when req_valid && req_ready.
- Acceptance (cycle 0):
  - Latch req_addr[1:0], req_size and req_unsigned.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Misaligned: next state ERR, no strobe.
  - Aligned: next state ISSUE; mem_addr <= {req_addr[ADDR_W-1:2],2'b00}.
- ISSUE (cycle 1):
  - mem_rstrb=1; the counter loads LATENCY-1; next state WAIT.
  - mem_addr holds its value until the next acceptance.
- WAIT (cycles 2..1+LATENCY):
  - mem_rdata is sampled only in the final WAIT cycle (counter==0). On that clock edge rsp_data is registered from the extracted value, and next state is RESP.
  - mem_rdata is ignored at all other times.
- RESP (cycle 2+LATENCY; cycle 3 at the default): rsp_valid=1, rsp_err=0.
- ERR (cycle 1): rsp_valid=1, rsp_err=1, rsp_data=0.
- From RESP or ERR: a new acceptance follows the acceptance rules above; otherwise go to IDLE. rsp_data holds its value until the next response.
- Extraction:
  - word: rdata.
  - half: addr[1] ? rdata[31:16] : rdata[15:0].
  - byte: lane addr[1:0]; lane 0 = rdata[7:0], lane 3 = rdata[31:24].
  - Sign-extend from bit 15 or bit 7 unless req_unsigned=1.
- Request inputs are ignored while req_ready=0; the core must hold them until accepted.
- rsp_valid and rsp_err are never high outside RESP or ERR. mem_rstrb is never high outside ISSUE.
- Maximum throughput: one request per 2+LATENCY cycles.

Test Plan:
- Reset: resetn=0 mid-WAIT, then release, with req_valid=0 → mem_rstrb=0 and rsp_valid=0 throughout. The next request completes normally.
- Word load: MEM[2]=0x8000F0A5; req addr 0x08, size 2 → mem_rstrb high in cycle 1 only, mem_addr=0x08; rsp_valid in cycle 3 with rsp_data=0x8000F0A5.
- Byte/half extraction, MEM[2]=0x8000F0A5:
  - addr 0x08 byte signed → 0xFFFFFFA5.
  - addr 0x09 byte unsigned → 0x000000F0.
  - addr 0x0A half signed → 0xFFFF8000.
  - addr 0x0B byte unsigned → 0x00000080.
- Misaligned: addr 0x0A word, then addr 0x0D half → each gives rsp_valid=1, rsp_err=1, rsp_data=0 in cycle 1; mem_rstrb stays 0.
- Back-to-back: req_valid held high with addresses 0x00, 0x04, 0x08 → accepted on the RESP cycles. Responses arrive in address order, 3 cycles apart; req_ready=0 during ISSUE and WAIT.
- LATENCY=3 with a delayed memory model → rsp_valid in cycle 5. Garbage driven on mem_rdata in the earlier WAIT cycles does not affect rsp_data.

Source files
------------

// File: rtl/mem_read_master_if.sv
// mem_read_master_if: core load request/response and memory read bus.
interface mem_read_master_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rstrb;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_addr, req_size, req_unsigned, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_rstrb
    );
    modport slave (
        output req_valid, req_addr, req_size, req_unsigned, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_rstrb
    );
endinterface

// File: rtl/mem_read_master.sv
// mem_read_master: single-outstanding load initiator with byte/half/word extraction.
module mem_read_master #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input logic              clk,
    input logic              resetn,
    mem_read_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
    state_t      state, nxt;
    logic        rdy, accept, mis;
    logic [3:0]  cnt;
    logic [1:0]  lo, size;
    logic        uns;
    logic [15:0] h16;
    logic [7:0]  b8;
    logic [31:0] ext;

    always_comb begin
        accept = bus.req_valid && rdy;
        mis = (bus.req_size == 2'd1 && bus.req_addr[0]) ||
              (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
        h16 = lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        b8 = bus.mem_rdata[{lo, 3'b000} +: 8];
        ext = size[1] ? bus.mem_rdata :
              size[0] ? {{16{~uns & h16[15]}}, h16} : {{24{~uns & b8[7]}}, b8};
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = rdy ? (accept ? (mis ? ERR : ISSUE) : IDLE) :
              state == ISSUE ? WAIT :
              cnt == 4'd0 ? RESP : WAIT;
    end

    always_comb begin
        rdy = state == IDLE || state == RESP || state == ERR;
        bus.req_ready = rdy;
        bus.mem_rstrb = state == ISSUE;
        bus.rsp_valid = state == RESP || state == ERR;
        bus.rsp_err = state == ERR;
    end

    // Latched request fields drive extraction while the read is in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lo <= '0;
            size <= '0;
            uns <= 1'b0;
            cnt <= '0;
            bus.mem_addr <= '0;
            bus.rsp_data <= '0;
        end else begin
            if (accept) begin
                lo <= bus.req_addr[1:0];
                size <= bus.req_size;
                uns <= bus.req_unsigned;
                if (mis) bus.rsp_data <= '0;
                else bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
            if (state == ISSUE) cnt <= 4'(LATENCY - 1);
            else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd0) bus.rsp_data <= ext;
        end
    end
endmodule

// File: tb/tb_mem_read_master.sv
// tb_mem_read_master: directed vectors for LATENCY=1 and LATENCY=3 instances.
module tb_mem_read_master;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_read_master_if b1 ();
    mem_read_master_if b3 ();
    mem_read_master #(.LATENCY(1), .ADDR_W(32)) d1 (.clk(clk), .resetn(resetn), .bus(b1.master));
    mem_read_master #(.LATENCY(3), .ADDR_W(32)) d3 (.clk(clk), .resetn(resetn), .bus(b3.master));

    logic [31:0] mem [0:15];
    logic [31:0] addr = '0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0, v1 = 1'b0, v3 = 1'b0, sel = 1'b0;

    assign b1.req_valid = v1;
    assign b1.req_addr = addr;
    assign b1.req_size = size;
    assign b1.req_unsigned = uns;
    assign b3.req_valid = v3;
    assign b3.req_addr = addr;
    assign b3.req_size = size;
    assign b3.req_unsigned = uns;

    // Memory models: real data only in the final wait cycle, inverted data otherwise.
    logic        live1 = 1'b0, live3 = 1'b0;
    logic [3:0]  k1 = '0, k3 = '0;
    logic [31:0] ma1 = '0, ma3 = '0;
    always @(posedge clk) begin
        if (b1.mem_rstrb) begin live1 <= 1'b1; k1 <= 4'd0; ma1 <= b1.mem_addr; end
        else if (live1 && k1 != 4'd0) k1 <= k1 - 4'd1;
        else live1 <= 1'b0;
        if (b3.mem_rstrb) begin live3 <= 1'b1; k3 <= 4'd2; ma3 <= b3.mem_addr; end
        else if (live3 && k3 != 4'd0) k3 <= k3 - 4'd1;
        else live3 <= 1'b0;
    end
    assign b1.mem_rdata = (live1 && k1 == 4'd0) ? mem[ma1[5:2]] : ~mem[ma1[5:2]];
    assign b3.mem_rdata = (live3 && k3 == 4'd0) ? mem[ma3[5:2]] : ~mem[ma3[5:2]];

    logic        o_ready, o_valid, o_err, o_rstrb;
    logic [31:0] o_data, o_maddr;
    assign o_ready = sel ? b3.req_ready : b1.req_ready;
    assign o_valid = sel ? b3.rsp_valid : b1.rsp_valid;
    assign o_err   = sel ? b3.rsp_err : b1.rsp_err;
    assign o_rstrb = sel ? b3.mem_rstrb : b1.mem_rstrb;
    assign o_data  = sel ? b3.rsp_data : b1.rsp_data;
    assign o_maddr = sel ? b3.mem_addr : b1.mem_addr;

    int checks = 0, failures = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input int lat, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] exp, input logic err);
        sel = (lat == 3);
        addr = a;
        size = s;
        uns = u;
        if (lat == 3) v3 = 1'b1;
        else v1 = 1'b1;
        #1;
        check("ready_idle", o_ready, 1);
        step();
        v1 = 1'b0;
        v3 = 1'b0;
        if (err) begin
            check("err_valid", o_valid, 1);
            check("err_flag", o_err, 1);
            check("err_data", o_data, 0);
            check("err_strobe", o_rstrb, 0);
            step();
            check("err_end", o_valid, 0);
            check("err_nostrobe", o_rstrb, 0);
        end else begin
            check("strobe", o_rstrb, 1);
            check("mem_addr", o_maddr, {a[31:2], 2'b00});
            check("issue_ready", o_ready, 0);
            check("issue_valid", o_valid, 0);
            for (int c = 0; c < lat; c++) begin
                step();
                check("wait_strobe", o_rstrb, 0);
                check("wait_valid", o_valid, 0);
                check("wait_ready", o_ready, 0);
            end
            step();
            check("rsp_valid", o_valid, 1);
            check("rsp_err", o_err, 0);
            check("rsp_data", o_data, exp);
            check("rsp_strobe", o_rstrb, 0);
            step();
            check("rsp_end", o_valid, 0);
            check("rsp_hold", o_data, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  s;
        logic        u;
        logic [31:0] e;
        logic        err;
    } vec_t;
    vec_t tv [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h01010101 * i;
        mem[0] = 32'h01234567;
        mem[1] = 32'h89ABCDEF;
        mem[2] = 32'h8000F0A5;
        tv[0]  = '{32'h08, 2'd2, 1'b0, 32'h8000F0A5, 1'b0};
        tv[1]  = '{32'h08, 2'd0, 1'b0, 32'hFFFFFFA5, 1'b0};
        tv[2]  = '{32'h09, 2'd0, 1'b1, 32'h000000F0, 1'b0};
        tv[3]  = '{32'h0A, 2'd1, 1'b0, 32'hFFFF8000, 1'b0};
        tv[4]  = '{32'h0B, 2'd0, 1'b1, 32'h00000080, 1'b0};
        tv[5]  = '{32'h0A, 2'd2, 1'b0, 32'h00000000, 1'b1};
        tv[6]  = '{32'h0D, 2'd1, 1'b0, 32'h00000000, 1'b1};
        tv[7]  = '{32'h0A, 2'd1, 1'b1, 32'h00008000, 1'b0};
        tv[8]  = '{32'h09, 2'd0, 1'b0, 32'hFFFFFFF0, 1'b0};
        tv[9]  = '{32'h08, 2'd1, 1'b0, 32'hFFFFF0A5, 1'b0};
        tv[10] = '{32'h04, 2'd3, 1'b0, 32'h89ABCDEF, 1'b0};
        tv[11] = '{32'h07, 2'd0, 1'b0, 32'hFFFFFF89, 1'b0};
        tv[12] = '{32'h01, 2'd0, 1'b0, 32'h00000045, 1'b0};
        tv[13] = '{32'h06, 2'd1, 1'b1, 32'h000089AB, 1'b0};
        tv[14] = '{32'h0E, 2'd3, 1'b1, 32'h00000000, 1'b1};
        tv[15] = '{32'h03, 2'd0, 1'b0, 32'h00000001, 1'b0};

        step();
        step();
        check("rst_valid", b1.rsp_valid, 0);
        check("rst_err", b1.rsp_err, 0);
        check("rst_data", b1.rsp_data, 0);
        check("rst_maddr", b1.mem_addr, 0);
        check("rst_strobe", b1.mem_rstrb, 0);
        check("rst_ready", b1.req_ready, 1);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 16; i++) xact(1, tv[i].a, tv[i].s, tv[i].u, tv[i].e, tv[i].err);

        xact(3, 32'h08, 2'd2, 1'b0, 32'h8000F0A5, 1'b0);
        xact(3, 32'h0B, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0);
        xact(3, 32'h02, 2'd1, 1'b1, 32'h00000123, 1'b0);
        xact(3, 32'h0D, 2'd1, 1'b0, 32'h00000000, 1'b1);

        sel = 1'b0;
        size = 2'd2;
        uns = 1'b0;
        v1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(4 * i);
            step();
            check("b2b_strobe", o_rstrb, 1);
            check("b2b_maddr", o_maddr, 32'(4 * i));
            check("b2b_issue_ready", o_ready, 0);
            step();
            check("b2b_wait_ready", o_ready, 0);
            check("b2b_wait_valid", o_valid, 0);
            step();
            check("b2b_valid", o_valid, 1);
            check("b2b_data", o_data, mem[i]);
            check("b2b_ready", o_ready, 1);
        end
        v1 = 1'b0;
        step();
        check("b2b_end", o_valid, 0);

        addr = 32'h08;
        size = 2'd2;
        v1 = 1'b1;
        step();
        v1 = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        check("mid_rst_strobe", o_rstrb, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_maddr", o_maddr, 0);
        check("mid_rst_ready", o_ready, 1);
        step();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_valid", o_valid, 0);
            check("post_rst_strobe", o_rstrb, 0);
        end
        xact(1, 32'h0A, 2'd1, 1'b0, 32'hFFFF8000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
